// File: rtl/shifter_arbiter.sv
// Round-robin sharing of one 16-bit barrel shifter among NREQ requesters,
// with a single registered result slot under valid/ready backpressure.

module barrelshifter16 (
    input  logic [15:0] din,
    input  logic [3:0]  amt,
    input  logic [1:0]  op,
    output logic [15:0] dout
);
    logic [4:0] inv_amt;

    // Shifting a 16-bit value by 16 yields 0, so amt=0 rotates stay exact.
    always_comb begin
        inv_amt = 5'd16 - {1'b0, amt};
        case (op)
            2'b00:   dout = din << amt;
            2'b01:   dout = din >> amt;
            2'b10:   dout = (din << amt) | (din >> inv_amt);
            default: dout = (din >> amt) | (din << inv_amt);
        endcase
    end
endmodule

// state | meaning
// EMPTY | result register holds nothing; any pending request may be granted
// FULL  | result register holds a result waiting for rsp_ready
module shifter_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [16*NREQ-1:0]  req_data,
    input  logic [4*NREQ-1:0]   req_amt,
    input  logic [2*NREQ-1:0]   req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          busy_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;
    logic           found;
    logic           can_accept;
    logic           grant;
    logic [15:0]    sel_data;
    logic [3:0]     sel_amt;
    logic [1:0]     sel_op;
    logic [15:0]    shifted;

    assign rsp_valid = (state_q == FULL);

    // Search from ptr upward, wrapping; the extra cand bit absorbs the carry.
    always_comb begin
        can_accept = (state_q == EMPTY) || rsp_ready;
        found      = 1'b0;
        gnt_idx    = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
        grant     = found && can_accept && !rst;
        req_ready = '0;
        if (grant)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        sel_op   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                sel_data = req_data[16*k +: 16];
                sel_amt  = req_amt[4*k +: 4];
                sel_op   = req_op[2*k +: 2];
            end
        end
    end

    barrelshifter16 u_shifter (
        .din  (sel_data),
        .amt  (sel_amt),
        .op   (sel_op),
        .dout (shifted)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (grant) state_d = FULL;
            FULL:    if (rsp_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            busy_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                rsp_data <= shifted;
                rsp_id   <= gnt_idx;
            end
            if (|req_valid && !can_accept && busy_cnt != 8'hFF)
                busy_cnt <= busy_cnt + 8'd1;
        end
    end
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one 16-bit barrel shifter datapath (`barrelshifter16`, instantiated internally) between NREQ independent requesters.
- Each requester presents an operand, a shift amount and an op over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The shifted result is captured in a single output register with valid/ready backpressure and returned with the requester's id.
- Sits between the issue logic of the shift-using units and the shared shifter.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of the requester id; must equal clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_data  in  16*NREQ  operands; requester k occupies bits [16k+15:16k].
- req_amt  in  4*NREQ  shift amounts 0..15; requester k occupies bits [4k+3:4k].
- req_op  in  2*NREQ  ops; requester k occupies bits [2k+1:2k]. Encoding: 00 logical shift left, 01 logical shift right, 10 rotate left, 11 rotate right.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  16  shifted result.
- rsp_id  out  IDW  index of the requester that produced rsp_data.
- busy_cnt  out  8  saturating count of cycles in which requests were pending but none were accepted.

Behaviour:
- **Reset** (rst high at a clock edge, takes priority over everything):
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy_cnt=0, priority pointer=0.
  - req_ready is forced to 0 while rst is high.
  - Reset in the middle of a backpressured transfer discards the held result; no request is accepted in that cycle.
- **State machine** (two states):
  - EMPTY (rsp_valid=0) → FULL when a grant occurs.
  - FULL → EMPTY when rsp_ready=1 and no new grant occurs.
  - FULL → FULL (reload) when rsp_ready=1 and a grant occurs in the same cycle.
  - FULL → FULL (hold) when rsp_ready=0. rsp_data and rsp_id must stay stable until the handshake completes.
- **Accept condition:** can_accept = (state==EMPTY) | rsp_ready. This gives full throughput of one result per cycle while the consumer is ready.
- **Arbitration:**
  - When can_accept=1, grant the first k with req_valid[k]=1, searching from ptr upward and wrapping modulo NREQ.
  - req_ready[k]=1 only for the granted k. req_ready is a combinational function of req_valid, ptr, state and rsp_ready; it never depends on req_data.
  - On a grant to k, ptr becomes (k+1) mod NREQ. With no grant, ptr is unchanged.
- **Datapath and latency:**
  - The granted requester's operand, amount and op drive the shifter combinationally.
  - The shifter output is registered into rsp_data, and k into rsp_id, on the granting edge. Latency is 1 cycle from accept to rsp_valid.
- **Arithmetic:**
  - amt=0 passes the operand through unchanged for all ops.
  - Logical shifts fill vacated bits with 0.
  - Rotates are modulo 16.
- **Requester rules:**
  - A requester holding req_valid high must keep its data, amt and op stable until accepted.
  - Dropping req_valid before acceptance is a protocol violation; behaviour is undefined and is not checked.
- **busy_cnt:** increments when at least one req_valid bit is high and can_accept=0. It saturates at 255 and clears only on reset.
- **Simultaneous events:** when all requesters are valid continuously, each is granted exactly once every NREQ accepting cycles. No requester waits more than NREQ accepting cycles.

Test Plan:
1. Reset, then requester 0 sends data=16'h8001, amt=1, op=10 with rsp_ready=1 → req_ready[0] high in the same cycle; next cycle rsp_valid=1, rsp_data=16'h0003, rsp_id=0.
2. Single-op checks on requester 2, one op at a time:
   - 16'hF0F0, amt 4, op 01 → 16'h0F0F.
   - 16'h00AB, amt 8, op 00 → 16'hAB00.
   - 16'h1234, amt 4, op 11 → 16'h4123.
   - 16'hBEEF, amt 0, any op → 16'hBEEF.
   - All results have rsp_id=2.
3. All four requesters valid continuously with rsp_ready=1 → grants and rsp_id sequence 0,1,2,3,0,1,… with one result per cycle and no gaps.
4. Result pending and rsp_ready held 0 for 3 cycles while requesters 1 and 3 are valid → rsp_data and rsp_id unchanged, req_ready=0, busy_cnt=3. When rsp_ready rises, requester 1 is granted in that same cycle.
5. Result held under backpressure (rsp_ready=0), then rst asserted for 1 cycle → after the edge rsp_valid=0, busy_cnt=0, ptr=0. The first post-reset contest between requesters 1 and 0 grants requester 0.
6. Requester 3 alone valid for 300 cycles with rsp_ready=0 after the first accept → busy_cnt saturates at 255. Results resume when rsp_ready=1.
